aes_key_expand: RTL and testbench
=================================

AES_KEY_EXPAND -- requirements
Module: aes_key_expand

Interface
REQ-001 Parameter: MAX_NK, default 8, meaning the largest key length supported in 32-bit words (4, 6 or 8).
REQ-002 Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- start, in, 1, request expansion.
- ready, out, 1, idle and able to accept start.
- key_len, in, 2, key size: 00=128, 01=192, 10=256.
- key, in, 256, cipher key, MSB-aligned; w0 = key[255:224].
- busy, out, 1, expansion in progress.
- rk_valid, out, 1, one-cycle round-key strobe.
- rk_idx, out, 4, round number of rk.
- rk, out, 128, round key; word 4r in bits [127:96].
- done, out, 1, one-cycle completion strobe.
- err, out, 1, one-cycle rejected-request strobe.
- rd_addr, in, 4, stored round-key index.
- rd_data, out, 128, stored round key.
REQ-003 Clock is clk; reset is rst, synchronous and active-high; single clock domain.

Function
REQ-004 start is accepted only at an edge where start && ready; key and key_len are captured at that edge; start while busy is ignored.
REQ-005 Nk/Nr are 4/10, 6/12 or 8/14; total words 4*(Nr+1) = 44, 52 or 60.
REQ-006 FSM states:
- IDLE: ready=1. start with a valid key_len goes to EXPAND; start with an invalid key_len goes to IDLE with err.
- EXPAND: busy=1. Returns to IDLE after the last word.
REQ-007 key_len is invalid when it is 11 or when its Nk exceeds MAX_NK; err is high in cycle T+1 only, and no rk_valid or done is generated.
REQ-008 Word engine: one word w[i] per cycle in EXPAND; i runs 0..total-1 during cycles T+1+i, where T is the accept cycle.
REQ-009 Word computation:
- i<Nk: w[i] is key word i.
- i%Nk==0: w[i] = w[i-Nk] ^ SubWord(RotWord(w[i-1])) ^ {rcon,24'h0}.
- Nk==8 and i%Nk==4: w[i] = w[i-Nk] ^ SubWord(w[i-1]).
- Otherwise: w[i] = w[i-Nk] ^ w[i-1].
REQ-010 The sliding window holds the last MAX_NK words as a shift register; no full word array is kept.
REQ-011 rcon starts at 8'h01 per request and advances by GF(2^8) xtime after each use: 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
REQ-012 Round-key output timing:
- rk_valid is registered, high in cycle T+5+4r for r=0..Nr.
- rk_idx=r, and rk holds w[4r..4r+3].
- rk and rk_idx hold their value between strobes.
REQ-013 done is high in the same cycle as the last rk_valid (T+5+4Nr: T+45, T+53 or T+61 for 128/192/256).
REQ-014 ready rises in the done cycle; a start accepted in the done cycle begins a new expansion with no gap.
REQ-015 busy is high from T+1 through the cycle before done.

Reset
REQ-016 rst at any edge, including mid-expansion, forces IDLE. In the following cycle: ready=1, busy=rk_valid=done=err=0, rk=0, rk_idx=0, rcon=01. Any partial expansion is discarded with no strobes.
REQ-017 Stored round keys are not cleared by rst.

Configuration
REQ-018 Macro AES_KEYEXP_STORE_EN.
- Defined: a 15x128 register file stores each round key at rk_valid, at address r. rd_data = entry[rd_addr], registered, with 1-cycle latency. rd_addr > 14 returns 0.
- Undefined: no storage is built, and rd_data is constant 0.

Structure
REQ-019 Package aes_pkg holds:
- key_len encoding constants.
- NK/NR lookup functions.
- RCON_INIT.
- xtime function.
- State enum for the FSM.
REQ-020 Sub-module aes_sbox_word: combinational 32-bit SubWord using four FIPS-197 S-box lookups. It is instantiated once and shared by both SubWord cases.

Verification
REQ-021 AES-128, key 2b7e151628aed2a6abf7158809cf4f3c -> rk_idx 0 equals the key; rk_idx 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; done at T+45.
REQ-022 AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> rk_idx 12 = e98ba06f448c773c8ecc720401002202; done at T+53.
REQ-023 AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> rk_idx 14 = fe4890d1e6188d0b046df344706c631e; done at T+61.
REQ-024 key_len=11, and key_len=10 with MAX_NK=4 -> err high 1 cycle, ready stays 1, no rk_valid.
REQ-025 Mid-operation and back-to-back:
- rst asserted at T+20 of a 128 run -> IDLE next cycle, no further strobes; a new start then yields correct vectors.
- start held high through done -> second run begins with round-0 key at done cycle+5.
REQ-026 With AES_KEYEXP_STORE_EN, after the AES-128 run, rd_addr=10 -> rd_data = d014f9a8c9ee2589e13f0cc8b6630ca6 one cycle later; without the macro, rd_data=0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared definitions for the AES key-expansion block: key-length encodings,
// Nk/Nr lookups, the round-constant seed, GF(2^8) xtime and the FSM state type.
package aes_pkg;

    // key_len encodings as seen on the key_len port
    localparam logic [1:0] KEY_LEN_128 = 2'b00;
    localparam logic [1:0] KEY_LEN_192 = 2'b01;
    localparam logic [1:0] KEY_LEN_256 = 2'b10;

    // First round constant of every expansion
    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } state_t;

    // Key length in 32-bit words; 0 flags the reserved encoding
    function automatic logic [3:0] nk_of(input logic [1:0] key_len);
        case (key_len)
            KEY_LEN_128: nk_of = 4'd4;
            KEY_LEN_192: nk_of = 4'd6;
            KEY_LEN_256: nk_of = 4'd8;
            default:     nk_of = 4'd0;
        endcase
    endfunction

    // Number of rounds; 0 flags the reserved encoding
    function automatic logic [3:0] nr_of(input logic [1:0] key_len);
        case (key_len)
            KEY_LEN_128: nr_of = 4'd10;
            KEY_LEN_192: nr_of = 4'd12;
            KEY_LEN_256: nr_of = 4'd14;
            default:     nr_of = 4'd0;
        endcase
    endfunction

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Cyclic left rotation of a word by one byte
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        rot_word = {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// SubWord: applies the FIPS-197 S-box to each byte of a 32-bit word.
// Purely combinational; one instance is shared by both SubWord cases of the
// key schedule.
module aes_sbox_word (
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);

    // S-box table, entry 0 leftmost
    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign o_word = {SBOX[i_word[31:24]], SBOX[i_word[23:16]],
                     SBOX[i_word[15:8]],  SBOX[i_word[7:0]]};

endmodule

// File: rtl/aes_key_expand.sv
// AES key expansion (128/192/256) producing one schedule word per cycle and
// strobing out each 128-bit round key as soon as its fourth word is known.
// Only the last MAX_NK words are kept in a sliding window.
// Build option: define AES_KEYEXP_STORE_EN to add a 15 x 128 round-key
// register file readable through rd_addr/rd_data (1-cycle read latency).
// Without it rd_data is tied to zero.
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int MAX_NK = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         ready,
    input  logic [1:0]   key_len,
    input  logic [255:0] key,
    output logic         busy,
    output logic         rk_valid,
    output logic [3:0]   rk_idx,
    output logic [127:0] rk,
    output logic         done,
    output logic         err,
    input  logic [3:0]   rd_addr,
    output logic [127:0] rd_data
);

    localparam logic [3:0] MAX_NK_W = 4'(MAX_NK);

    // Control state
    state_t                  r_state;
    logic [3:0]              r_nk;       // Nk of the running request
    logic [5:0]              r_last;     // index of the final word
    logic [5:0]              r_i;        // word index being produced
    logic [3:0]              r_j;        // r_i mod Nk
    logic [7:0]              r_rcon;

    // Datapath state
    logic [255:0]            r_key;      // captured key, consumed MSB-first
    logic [MAX_NK-1:0][31:0] r_win;      // r_win[k] = w[i-1-k]

    // Registered outputs
    logic                    r_rk_valid;
    logic                    r_done;
    logic                    r_err;
    logic [3:0]              r_rk_idx;
    logic [127:0]            r_rk;

    logic [3:0]              w_nk_req;
    logic                    w_len_ok;
    logic                    w_accept;
    logic                    w_is_key;
    logic                    w_rk_step;
    logic [31:0]             w_far;
    logic [31:0]             w_near;
    logic [31:0]             w_sub_in;
    logic [31:0]             w_sub_out;
    logic [31:0]             w_word;
    logic [127:0]            w_rk_next;

    // Request decode: reserved encoding or a key longer than the build supports is rejected
    assign w_nk_req = nk_of(key_len);
    assign w_len_ok = (w_nk_req != 4'd0) && (w_nk_req <= MAX_NK_W);
    assign w_accept = start && (r_state == ST_IDLE);

    assign w_is_key  = r_i < {2'b00, r_nk};
    assign w_near    = r_win[0];
    assign w_rk_step = (r_state == ST_EXPAND) && (r_i[1:0] == 2'b11);

    // Select w[i-Nk] from the window according to the running key length
    always_comb begin
        // NOTE: defaulting every always_comb output first keeps the loop from inferring a latch
        w_far = '0;
        for (int k = 0; k < MAX_NK; k++) begin
            if (r_nk == 4'(k + 1)) begin
                w_far = r_win[k];
            end
        end
    end

    // One shared S-box: RotWord is applied only on the i mod Nk == 0 step
    assign w_sub_in = (r_j == 4'd0) ? rot_word(w_near) : w_near;

    aes_sbox_word u_sbox (
        .i_word (w_sub_in),
        .o_word (w_sub_out)
    );

    // Next schedule word
    always_comb begin
        w_word = w_far ^ w_near;
        if (w_is_key) begin
            w_word = r_key[255:224];
        end else if (r_j == 4'd0) begin
            w_word = w_far ^ w_sub_out ^ {r_rcon, 24'h0};
        end else if ((r_nk == 4'd8) && (r_j == 4'd4)) begin
            w_word = w_far ^ w_sub_out;
        end
    end

    // Round key completed by the word produced this cycle
    assign w_rk_next = {r_win[2], r_win[1], r_win[0], w_word};

    // FSM, word/rcon counters and output strobes
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order
        if (rst) begin
            r_state    <= ST_IDLE;
            r_nk       <= 4'd4;
            r_last     <= '0;
            r_i        <= '0;
            r_j        <= '0;
            r_rcon     <= RCON_INIT;
            r_rk_valid <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_rk_idx   <= '0;
            r_rk       <= '0;
        end else begin
            r_rk_valid <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_len_ok) begin
                            r_state <= ST_EXPAND;
                            r_nk    <= w_nk_req;
                            r_last  <= {nr_of(key_len), 2'b11};
                            r_i     <= '0;
                            r_j     <= '0;
                            r_rcon  <= RCON_INIT;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_EXPAND: begin
                    r_i <= r_i + 6'd1;
                    r_j <= (r_j == r_nk - 4'd1) ? 4'd0 : r_j + 4'd1;
                    if (!w_is_key && (r_j == 4'd0)) begin
                        r_rcon <= xtime(r_rcon);
                    end
                    if (w_rk_step) begin
                        r_rk_valid <= 1'b1;
                        r_rk_idx   <= r_i[5:2];
                        r_rk       <= w_rk_next;
                    end
                    if (r_i == r_last) begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Key capture and sliding window; pure datapath, always overwritten before use
    always_ff @(posedge clk) begin
        if (w_accept && w_len_ok) begin
            r_key <= key;
        end else if (r_state == ST_EXPAND) begin
            r_key <= {r_key[223:0], 32'h0};
        end
        if (r_state == ST_EXPAND) begin
            r_win <= {r_win[MAX_NK-2:0], w_word};
        end
    end

    assign ready    = (r_state == ST_IDLE);
    assign busy     = (r_state == ST_EXPAND);
    assign rk_valid = r_rk_valid;
    assign rk_idx   = r_rk_idx;
    assign rk       = r_rk;
    assign done     = r_done;
    assign err      = r_err;

`ifdef AES_KEYEXP_STORE_EN
    logic [127:0] r_store [15];
    logic [127:0] r_rd_data;
    logic         w_store_we;

    assign w_store_we = !rst && w_rk_step;

    // Round-key register file, written alongside each rk strobe
    always_ff @(posedge clk) begin
        // NOTE: storage arrays carry no reset so they map onto plain register/RAM cells and survive rst
        if (w_store_we) begin
            r_store[r_i[5:2]] <= w_rk_next;
        end
    end

    // Registered read port; addresses past the last round read as zero
    always_ff @(posedge clk) begin
        r_rd_data <= (rd_addr <= 4'd14) ? r_store[rd_addr] : '0;
    end

    assign rd_data = r_rd_data;
`else
    logic w_unused_rd_addr;

    assign w_unused_rd_addr = ^rd_addr;
    assign rd_data          = '0;
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand: FIPS-197 vectors for all three key
// sizes from a table, plus rejection, mid-run reset, storage read-back and
// back-to-back sequences. A second instance is built with MAX_NK=4.
module tb_aes_key_expand;

    logic         clk;
    logic         rst;
    logic         start;
    logic [1:0]   key_len;
    logic [255:0] key;
    logic [3:0]   rd_addr;
    logic         ready, busy, rk_valid, done, err;
    logic [3:0]   rk_idx;
    logic [127:0] rk, rd_data;
    logic         d4_ready, d4_busy, d4_rk_valid, d4_done, d4_err;
    logic [3:0]   d4_rk_idx;
    logic [127:0] d4_rk, unused_d4_rd_data;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] RK128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    typedef struct {
        logic [1:0]   key_len;
        logic [255:0] key;
        int           nr;
        int           done_ofs;
        logic [127:0] rk0;
        int           mid_idx;
        logic [127:0] rk_mid;
        logic [127:0] rk_last;
    } vec_t;

    vec_t vecs [3];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int t_acc    = 0;

    // Per-run observations gathered by capture()
    int           n_strobe, n_err, err_ofs, done_ofs, order_bad, busy_bad;
    int           ready_low, d4_err_cnt, d4_active;
    logic         ready_at_done;
    logic [127:0] cap_rk [16];
    logic [127:0] rd_val;

    aes_key_expand u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .ready    (ready),
        .key_len  (key_len),
        .key      (key),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_idx   (rk_idx),
        .rk       (rk),
        .done     (done),
        .err      (err),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    aes_key_expand #(.MAX_NK(4)) u_dut4 (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .ready    (d4_ready),
        .key_len  (key_len),
        .key      (key),
        .busy     (d4_busy),
        .rk_valid (d4_rk_valid),
        .rk_idx   (d4_rk_idx),
        .rk       (d4_rk),
        .done     (d4_done),
        .err      (d4_err),
        .rd_addr  (rd_addr),
        .rd_data  (unused_d4_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    // Present a request for one cycle; t_acc is the cycle in which it is sampled
    task automatic do_start(input logic [1:0] kl, input logic [255:0] k);
        @(posedge clk); #1;
        start   = 1'b1;
        key_len = kl;
        key     = k;
        @(negedge clk);
        t_acc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Observe the DUT at negedges until done or the cycle budget runs out
    task automatic capture(input int max_cycles, input logic expect_busy);
        int ofs;
        n_strobe = 0; n_err = 0; err_ofs = -1; done_ofs = -1;
        order_bad = 0; busy_bad = 0; ready_low = 0; ready_at_done = 1'b0;
        d4_err_cnt = 0; d4_active = 0;
        for (int k = 0; k < 16; k++) cap_rk[k] = '0;
        for (int c = 0; c < max_cycles; c++) begin
            @(negedge clk);
            ofs = cyc - t_acc;
            if (err) begin
                n_err++;
                if (err_ofs < 0) err_ofs = ofs;
            end
            if (d4_err) d4_err_cnt++;
            if (d4_busy || d4_rk_valid || d4_done || !d4_ready) d4_active++;
            if (!ready) ready_low++;
            if (rk_valid) begin
                if (rk_idx != 4'(n_strobe) || ofs != 5 + 4 * n_strobe) order_bad++;
                cap_rk[rk_idx] = rk;
                n_strobe++;
            end
            if (done) begin
                done_ofs      = ofs;
                ready_at_done = ready;
                if (busy) busy_bad++;
                break;
            end
            if (busy !== expect_busy) busy_bad++;
        end
    endtask

    task automatic read_store(input logic [3:0] a, output logic [127:0] d);
        @(posedge clk); #1;
        rd_addr = a;
        @(posedge clk);
        @(negedge clk);
        d = rd_data;
    endtask

    initial begin
        vecs[0] = '{2'b00, K128, 10, 45, K128[255:128], 1,
                    128'ha0fafe1788542cb123a339392a6c7605, RK128_10};
        vecs[1] = '{2'b01, K192, 12, 53, K192[255:128], 1,
                    128'h62f8ead2522c6b7bfe0c91f72402f5a5,
                    128'he98ba06f448c773c8ecc720401002202};
        vecs[2] = '{2'b10, K256, 14, 61, K256[255:128], 3,
                    128'ha8b09c1a93d194cdbe49846eb75d5b9a,
                    128'hfe4890d1e6188d0b046df344706c631e};

        rst = 1'b1; start = 1'b0; key_len = 2'b00; key = '0; rd_addr = 4'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_ready",    128'(ready),    128'd1);
        check("rst_busy",     128'(busy),     128'd0);
        check("rst_rk_valid", 128'(rk_valid), 128'd0);
        check("rst_done",     128'(done),     128'd0);
        check("rst_err",      128'(err),      128'd0);
        check("rst_rk",       rk,             128'd0);
        check("rst_rk_idx",   128'(rk_idx),   128'd0);

        // 256-bit request: rejected by the MAX_NK=4 build, served by the default build
        do_start(2'b10, K256);
        capture(80, 1'b1);
        check("d4_len256_err",    128'(d4_err_cnt), 128'd1);
        check("d4_len256_quiet",  128'(d4_active),  128'd0);
        check("d4_rk_untouched",  d4_rk,            128'd0);
        check("d4_idx_untouched", 128'(d4_rk_idx),  128'd0);
        check("len256_done_ofs",  128'(done_ofs),   128'd61);

        // Reserved key_len: one err pulse, no activity
        do_start(2'b11, K128);
        capture(12, 1'b0);
        check("len11_err_cnt",   128'(n_err),      128'd1);
        check("len11_err_ofs",   128'(err_ofs),    128'd1);
        check("len11_strobes",   128'(n_strobe),   128'd0);
        check("len11_no_done",   128'(done_ofs),   128'hffffffffffffffffffffffffffffffff);
        check("len11_ready_low", 128'(ready_low),  128'd0);
        check("len11_busy",      128'(busy_bad),   128'd0);
        check("d4_len11_err",    128'(d4_err_cnt), 128'd1);

        // FIPS-197 vectors
        for (int v = 0; v < 3; v++) begin
            do_start(vecs[v].key_len, vecs[v].key);
            capture(80, 1'b1);
            check($sformatf("v%0d_rk0", v),      cap_rk[0],                  vecs[v].rk0);
            check($sformatf("v%0d_rk_mid", v),   cap_rk[vecs[v].mid_idx],    vecs[v].rk_mid);
            check($sformatf("v%0d_rk_last", v),  cap_rk[vecs[v].nr],         vecs[v].rk_last);
            check($sformatf("v%0d_strobes", v),  128'(n_strobe),             128'(vecs[v].nr + 1));
            check($sformatf("v%0d_done_ofs", v), 128'(done_ofs),             128'(vecs[v].done_ofs));
            check($sformatf("v%0d_order", v),    128'(order_bad),            128'd0);
            check($sformatf("v%0d_busy", v),     128'(busy_bad),             128'd0);
            check($sformatf("v%0d_ready", v),    128'(ready_at_done),        128'd1);
            check($sformatf("v%0d_no_err", v),   128'(n_err),                128'd0);
            @(negedge clk);
            @(negedge clk);
            check($sformatf("v%0d_hold_idx", v), 128'(rk_idx),               128'(vecs[v].nr));
            check($sformatf("v%0d_hold_rk", v),  rk,                         vecs[v].rk_last);
        end

        // Reset in cycle T+20 of a 128-bit run
        do_start(2'b00, K128);
        repeat (19) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_ready",    128'(ready),    128'd1);
        check("midrst_busy",     128'(busy),     128'd0);
        check("midrst_rk_valid", 128'(rk_valid), 128'd0);
        check("midrst_rk",       rk,             128'd0);
        check("midrst_rk_idx",   128'(rk_idx),   128'd0);
        capture(70, 1'b0);
        check("midrst_strobes",  128'(n_strobe), 128'd0);
        check("midrst_no_done",  128'(done_ofs), 128'hffffffffffffffffffffffffffffffff);
        check("midrst_busy_run", 128'(busy_bad), 128'd0);

        do_start(2'b00, K128);
        capture(80, 1'b1);
        check("rerun_rk0",      cap_rk[0],        K128[255:128]);
        check("rerun_rk10",     cap_rk[10],       RK128_10);
        check("rerun_done_ofs", 128'(done_ofs),   128'd45);
        check("rerun_order",    128'(order_bad),  128'd0);

        // Round-key storage
`ifdef AES_KEYEXP_STORE_EN
        read_store(4'd10, rd_val);
        check("store_rd10", rd_val, RK128_10);
        read_store(4'd0, rd_val);
        check("store_rd0",  rd_val, K128[255:128]);
        read_store(4'd15, rd_val);
        check("store_rd15", rd_val, 128'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        read_store(4'd10, rd_val);
        check("store_after_rst", rd_val, RK128_10);
`else
        read_store(4'd10, rd_val);
        check("nostore_rd10", rd_val, 128'd0);
`endif
        rd_addr = 4'd0;

        // start held through done: 128-bit run, then a 256-bit run with no gap.
        // Key and key_len change while busy and must not disturb the first run.
        @(posedge clk); #1;
        start = 1'b1; key_len = 2'b00; key = K128;
        @(negedge clk);
        t_acc = cyc;
        @(posedge clk); #1;
        key_len = 2'b10; key = K256;
        capture(80, 1'b1);
        check("b2b1_rk10",     cap_rk[10],      RK128_10);
        check("b2b1_done_ofs", 128'(done_ofs),  128'd45);
        check("b2b1_ready",    128'(ready_at_done), 128'd1);
        t_acc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        capture(80, 1'b1);
        check("b2b2_rk0",      cap_rk[0],       K256[255:128]);
        check("b2b2_rk14",     cap_rk[14],      128'hfe4890d1e6188d0b046df344706c631e);
        check("b2b2_order",    128'(order_bad), 128'd0);
        check("b2b2_done_ofs", 128'(done_ofs),  128'd61);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
